// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised mid-bit sampling, valid/ready byte delivery,
// framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 27000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CntW        = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_CYCLES - 1);

  if (BIT_CYCLES < 4) begin : g_bad_cfg
    $error("uart_rx: CLK_FREQ / BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            overrun_q, overrun_d;
  logic            rx_meta_q, rx_s_q;
  logic            byte_done;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    data_valid_d  = data_valid_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    byte_done     = 1'b0;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // A completed byte loads if the slot is free or being drained this cycle.
    if (byte_done) begin
      if (!data_valid_q || data_ready) begin
        data_d       = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Counterpart of the uart_tx transmitter on the board's serial link.
- Samples the asynchronous rx pin at mid-bit and delivers each received byte to the core logic through a valid/ready handshake.
- Reports framing errors and overrun.
- Sits between the board uart_rx pin and the top-level logic, using the same CLK_FREQ/BAUD_RATE parameters as uart_tx.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; BIT_CYCLES = CLK_FREQ / BAUD_RATE (integer division, 234 at defaults); HALF_CYCLES = BIT_CYCLES / 2 (117); BIT_CYCLES >= 4 is required

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset (rst=0 resets all state immediately)
rx  input  1  asynchronous serial line, idle high
data  output  8  received byte, valid while data_valid=1
data_valid  output  1  byte available; held until accepted
data_ready  input  1  consumer accepts data when data_valid & data_ready at posedge
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new byte completed while previous byte not accepted
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: data=0x00, data_valid=0, frame_error=0, overrun=0, busy=0. Both synchroniser flops = 1. State = IDLE. Counters = 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Bit-cycle counter width is ceil(log2(BIT_CYCLES)). It is reset to 0 on every state transition.
- State machine:
  - IDLE: when rx_s=0, go to START.
  - START: when counter = HALF_CYCLES-1, sample rx_s:
    - 0: go to DATA, bit index = 0.
    - 1: glitch; go back to IDLE, no outputs.
  - DATA: when counter = BIT_CYCLES-1, sample rx_s into bit[index], LSB first. After index 7, go to STOP.
  - STOP: when counter = BIT_CYCLES-1, sample rx_s:
    - 1: frame complete; deliver byte (handshake rules below); go to IDLE.
    - 0: pulse frame_error for 1 cycle; discard byte; go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Latency: data_valid rises 2 + HALF_CYCLES + 9*BIT_CYCLES cycles (+/-2) after the rx falling edge. At defaults this is 2225.
- Handshake:
  - The byte is transferred when data_valid=1 and data_ready=1 at the same posedge.
  - data_valid deasserts on the next cycle unless a new byte loads in that same cycle.
  - data_ready is ignored while data_valid=0.
- Delivery when a frame completes:
  - data_valid=0: load data and set data_valid.
  - data_valid=1 and data_ready=1 in the same cycle: old byte is consumed, new byte loads, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: new byte is dropped, old data is kept, overrun pulses for 1 cycle.
- Reception continues regardless of consumer state. The handshake never stalls the receiver.
- frame_error and overrun are never asserted together. Each is high for exactly 1 cycle per event.
- Asserting rst mid-frame aborts the frame immediately and returns to the reset values. The partial byte is never delivered.
- After rst is released, a line that is already low is treated as a start edge only once rx_s is 0 in IDLE. A held-low line then resolves through STOP to frame_error and BREAK.

Test Plan:
1. Defaults. Send 0x55 (8N1, 234 cycles/bit), data_ready=0 -> data_valid rises 2223..2227 cycles after the start edge with data=0x55. data_valid stays high until data_ready=1 for one cycle, then drops the next cycle. busy is high from about cycle 3 until the stop sample.
2. Send back-to-back 0x41, 0x42, 0x00 with data_ready tied 1 -> three single-cycle data_valid pulses carrying 0x41, 0x42, 0x00. No frame_error, no overrun.
3. Drive rx low for 50 cycles then high -> busy pulses, then returns to 0 after the START sample. data_valid, frame_error and overrun stay 0.
4. Send 0xA3 with the stop bit driven 0, then hold rx low for 5000 cycles, then release -> frame_error is high for exactly 1 cycle. No data_valid. busy stays high until rx returns high. A following valid 0x3C frame is received correctly.
5. data_ready=0. Send 0x11 then 0x22 -> data=0x11 with data_valid held; overrun pulses for 1 cycle at the 0x22 stop sample; data remains 0x11. Assert data_ready -> data_valid drops.
6. Assert rst=0 during data bit 4 of 0xFF, release after 10 cycles, then send 0x7E -> all outputs are at reset values during reset. 0xFF is never delivered. 0x7E is delivered correctly.
